// File: rtl/dda_host_ctrl_if.sv
// -----------------------------------------------------------------------------
// dda_host_ctrl_if
// Byte-level UART link between the DDA host controller and the UART rx/tx.
//   rx_received : one-cycle pulse, rx_byte valid
//   rx_byte     : received byte
//   rx_error    : one-cycle pulse, framing error
//   tx_busy     : transmitter busy
//   tx_start    : one-cycle pulse, start sending tx_data
//   tx_data     : byte to transmit, stable until the next tx_start
// master = controller side, slave = UART side.
// -----------------------------------------------------------------------------
interface dda_host_ctrl_if;
  logic       rx_received;
  logic [7:0] rx_byte;
  logic       rx_error;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    input  rx_received, rx_byte, rx_error, tx_busy,
    output tx_start, tx_data
  );

  modport slave (
    output rx_received, rx_byte, rx_error, tx_busy,
    input  tx_start, tx_data
  );
endinterface

// File: rtl/dda_host_ctrl.sv
// -----------------------------------------------------------------------------
// dda_host_ctrl
// Host-side controller for the Lorenz DDA integrator. Decodes the byte command
// protocol, holds the parameter file, sequences DDA enable/load and streams
// state frames (SYNC, x, y, z big-endian) to the UART transmitter. The DDA is
// only enabled in SEQ_RUN, so frames are exactly DECIM steps apart.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   uart              : UART rx/tx handshake (master modport)
//   x_i, y_i, z_i     : DDA state variables
//   dda_en_o          : DDA advances one step per high cycle
//   dda_load_o        : one-cycle pulse, DDA reloads initial conditions
//   params_o          : parameter file, byte k at [8k+7:8k]
//   running_o         : free-run mode active
// The frame byte split assumes N = 16.
// -----------------------------------------------------------------------------
module dda_host_ctrl #(
  parameter int         N            = 16,
  parameter int         REG_SIZE     = 14,
  parameter int         DECIM        = 256,
  parameter logic [7:0] SYNC         = 8'hA5,
  parameter bit         RUN_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  dda_host_ctrl_if.master         uart,
  input  logic [N-1:0]            x_i,
  input  logic [N-1:0]            y_i,
  input  logic [N-1:0]            z_i,
  output logic                    dda_en_o,
  output logic                    dda_load_o,
  output logic [8*REG_SIZE-1:0]   params_o,
  output logic                    running_o
);

  localparam int AW = (REG_SIZE > 1) ? $clog2(REG_SIZE) : 1;
  localparam logic [15:0] DECIM_M1 = 16'(DECIM - 1);
  localparam logic [7:0] PARAM_RST [REG_SIZE] = '{
    8'hC0, 8'h00, 8'h14, 8'hCD, 8'h72, 8'h40, 8'h6A,
    8'h00, 8'h55, 8'h55, 8'h73, 8'h00, 8'h04, 8'h00};

  typedef enum logic [1:0] {CMD_IDLE = 2'd0, CMD_ADDR = 2'd1, CMD_DATA = 2'd2} cmd_e;
  typedef enum logic [1:0] {SEQ_RUN = 2'd0, SEQ_SNAP = 2'd1, SEQ_TX = 2'd2} seq_e;

  cmd_e          cmd_q, cmd_d;
  seq_e          seq_q, seq_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    param_q [REG_SIZE];
  logic          param_we;
  logic [AW-1:0] param_wa;
  logic [7:0]    param_wd;
  logic          running_q, running_d;
  logic          pend_q, pend_d;
  logic          do_p, do_i;
  logic [15:0]   cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          single_q, single_d;   // current enabled cycle is a single step
  logic          load_q, load_d;
  logic          snap;
  logic [N-1:0]  shx_q, shy_q, shz_q;
  logic [2:0]    idx_q, idx_d;
  logic [1:0]    guard_q, guard_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    frame_byte;

  // Command decoder: W addr data writes, R/S/P/I control; rx_error wins.
  always_comb begin
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    running_d = running_q;
    param_we  = 1'b0;
    param_wa  = addr_q[AW-1:0];
    param_wd  = uart.rx_byte;
    do_p      = 1'b0;
    do_i      = 1'b0;
    if (uart.rx_error) begin
      cmd_d = CMD_IDLE;
    end else if (uart.rx_received) begin
      case (cmd_q)
        CMD_IDLE: begin
          case (uart.rx_byte)
            8'h57:   cmd_d     = CMD_ADDR;
            8'h52:   running_d = 1'b1;
            8'h53:   running_d = 1'b0;
            8'h50:   do_p      = 1'b1;
            8'h49:   do_i      = 1'b1;
            default: cmd_d     = CMD_IDLE;
          endcase
        end
        CMD_ADDR: begin
          addr_d = uart.rx_byte;
          cmd_d  = CMD_DATA;
        end
        CMD_DATA: begin
          if (addr_q < 8'(REG_SIZE)) begin
            param_we = 1'b1;
          end else begin
            param_we = 1'b0;
          end
          cmd_d = CMD_IDLE;
        end
        default: cmd_d = CMD_IDLE;
      endcase
    end else begin
      cmd_d = cmd_q;
    end
  end

  // Frame byte selection from the shadow snapshot.
  always_comb begin
    case (idx_q)
      3'd0:    frame_byte = SYNC;
      3'd1:    frame_byte = shx_q[N-1 -: 8];
      3'd2:    frame_byte = shx_q[7:0];
      3'd3:    frame_byte = shy_q[N-1 -: 8];
      3'd4:    frame_byte = shy_q[7:0];
      3'd5:    frame_byte = shz_q[N-1 -: 8];
      3'd6:    frame_byte = shz_q[7:0];
      default: frame_byte = 8'h00;
    endcase
  end

  // Step/frame sequencer and TX handshake.
  always_comb begin
    seq_d      = seq_q;
    cnt_d      = cnt_q;
    en_d       = 1'b0;
    single_d   = 1'b0;
    load_d     = do_i;
    snap       = 1'b0;
    idx_d      = idx_q;
    guard_d    = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    if (do_p && !running_q) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
    case (seq_q)
      SEQ_RUN: begin
        // en_q marks a step taking place this cycle; decide the next one.
        if (en_q && (single_q || (cnt_q == DECIM_M1))) begin
          seq_d = SEQ_SNAP;
          cnt_d = 16'd0;
        end else begin
          cnt_d = cnt_q + {15'd0, en_q};
          if (do_i) begin
            en_d = 1'b0;             // load cycle must not step
          end else if (running_q) begin
            en_d   = 1'b1;
            pend_d = 1'b0;
          end else if (pend_q) begin
            en_d     = 1'b1;
            single_d = 1'b1;
            pend_d   = 1'b0;
          end else begin
            en_d = 1'b0;
          end
        end
      end
      SEQ_SNAP: begin
        snap  = 1'b1;
        idx_d = 3'd0;
        seq_d = SEQ_TX;
      end
      SEQ_TX: begin
        // Guard covers the cycles before the UART raises tx_busy.
        if ((guard_q != 2'd0) || uart.tx_busy) begin
          seq_d = SEQ_TX;
        end else if (idx_q == 3'd7) begin
          idx_d = 3'd0;
          seq_d = SEQ_RUN;
        end else begin
          tx_start_d = 1'b1;
          tx_data_d  = frame_byte;
          idx_d      = idx_q + 3'd1;
          guard_d    = 2'd3;
        end
      end
      default: seq_d = SEQ_RUN;
    endcase
    if (do_i) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= CMD_IDLE;
      addr_q     <= 8'h00;
      param_q    <= PARAM_RST;
      running_q  <= RUN_ON_RESET;
      pend_q     <= 1'b0;
      seq_q      <= SEQ_RUN;
      cnt_q      <= 16'd0;
      en_q       <= 1'b0;
      single_q   <= 1'b0;
      load_q     <= 1'b1;
      idx_q      <= 3'd0;
      guard_q    <= 2'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      running_q  <= running_d;
      pend_q     <= pend_d;
      seq_q      <= seq_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      single_q   <= single_d;
      load_q     <= load_d;
      idx_q      <= idx_d;
      guard_q    <= guard_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      if (param_we) begin
        param_q[param_wa] <= param_wd;
      end
    end
  end

  // Shadow snapshot of x, y, z taken in SEQ_SNAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      shx_q <= '0;
      shy_q <= '0;
      shz_q <= '0;
    end else if (snap) begin
      shx_q <= x_i;
      shy_q <= y_i;
      shz_q <= z_i;
    end
  end

  for (genvar k = 0; k < REG_SIZE; k++) begin : g_params
    assign params_o[8*k +: 8] = param_q[k];
  end

  assign dda_en_o      = en_q;
  assign dda_load_o    = load_q;
  assign running_o     = running_q;
  assign uart.tx_start = tx_start_q;
  assign uart.tx_data  = tx_data_q;

endmodule
